regfile_sync_read: RTL and testbench

- Register file on the consuming end of the writeback interface. It accepts the writeback stage's write enable, target and result, and serves two synchronous read ports to decode.
- Eight 16-bit registers; r0 is hardwired to zero.
- Read data is registered, with one-cycle latency. Same-cycle write-to-read bypass is built in.
- During halt, reads replay the latched addresses, so writes that land while halted are still observed.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/regfile_read_port.sv | 45 ++++
 rtl/regfile_sync_read.sv | 72 +++++++
 tb/tb_regfile_sync_read.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry, the r0 index and the opcode
// encoding that upstream stages use to qualify writeback enables.
package cpu_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int DATA_W     = 16;
  localparam int NREGS      = 1 << REG_ADDR_W;

  localparam logic [REG_ADDR_W-1:0] R0_IDX = '0;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SHL  = 4'h5,
    OP_SHR  = 4'h6,
    OP_LDI  = 4'h7,
    OP_LD   = 4'h8,
    OP_ST   = 4'h9,
    OP_BEQ  = 4'hA,
    OP_BNE  = 4'hB,
    OP_JMP  = 4'hC,
    OP_NOP  = 4'hF
  } opcode_e;

endpackage

// File: rtl/regfile_read_port.sv
// One synchronous read port: address latch held during halt, r0 forcing,
// same-edge write bypass and the registered data output.
module regfile_read_port
  import cpu_pkg::*;
(
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              halt,
  input  logic [REG_ADDR_W-1:0]             addr,
  input  logic                              we,
  input  logic [REG_ADDR_W-1:0]             wtgt,
  input  logic [DATA_W-1:0]                 wdata,
  input  logic [NREGS-1:0][DATA_W-1:0]      regs,
  output logic [DATA_W-1:0]                 data
);

  logic [REG_ADDR_W-1:0] addr_q;
  logic [REG_ADDR_W-1:0] eff_addr;
  logic [DATA_W-1:0]     data_next;

  // While halted the held address is replayed, so late writes still show up.
  assign eff_addr = halt ? addr_q : addr;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    data_next = regs[eff_addr];
    if (eff_addr == R0_IDX)
      data_next = '0;
    else if (we && (wtgt == eff_addr))
      data_next = wdata;
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      data   <= '0;
    end else begin
      if (!halt)
        addr_q <= addr;
      data <= data_next;
    end
  end

endmodule

// File: rtl/regfile_sync_read.sv
// Eight-entry register file with r0 hardwired to zero and two registered read
// ports. Optional debug port and write counter under `REGFILE_DEBUG_EN.
module regfile_sync_read
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  halt,
  input  logic [REG_ADDR_W-1:0] ra_addr,
  input  logic [REG_ADDR_W-1:0] rb_addr,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] wtgt,
  input  logic [DATA_W-1:0]     wdata,
`ifdef REGFILE_DEBUG_EN
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]     dbg_data,
  output logic [15:0]           wr_count,
`endif
  output logic [DATA_W-1:0]     ra_data,
  output logic [DATA_W-1:0]     rb_data
);

  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic                         wr_accept;

  assign wr_accept = we && (wtgt != R0_IDX);

  // NOTE: the array is built from flops, not RAM, so it can and does clear on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      regs <= '0;
    else if (wr_accept)
      regs[wtgt] <= wdata;
  end

  regfile_read_port u_port_a (
    .clk   (clk),
    .reset (reset),
    .halt  (halt),
    .addr  (ra_addr),
    .we    (we),
    .wtgt  (wtgt),
    .wdata (wdata),
    .regs  (regs),
    .data  (ra_data)
  );

  regfile_read_port u_port_b (
    .clk   (clk),
    .reset (reset),
    .halt  (halt),
    .addr  (rb_addr),
    .we    (we),
    .wtgt  (wtgt),
    .wdata (wdata),
    .regs  (regs),
    .data  (rb_data)
  );

`ifdef REGFILE_DEBUG_EN
  // Debug view is the raw array contents; it deliberately skips the bypass.
  assign dbg_data = (dbg_addr == R0_IDX) ? '0 : regs[dbg_addr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wr_count <= '0;
    else if (wr_accept)
      wr_count <= wr_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_regfile_sync_read.sv
// Scoreboard bench for regfile_sync_read: stimulus pushes expected read data,
// a monitor pops and compares one entry per clock edge.
module tb_regfile_sync_read;
  import cpu_pkg::*;

  logic                  clk;
  logic                  reset;
  logic                  halt;
  logic [REG_ADDR_W-1:0] ra_addr;
  logic [REG_ADDR_W-1:0] rb_addr;
  logic                  we;
  logic [REG_ADDR_W-1:0] wtgt;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W-1:0]     ra_data;
  logic [DATA_W-1:0]     rb_data;
`ifdef REGFILE_DEBUG_EN
  logic [REG_ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0]     dbg_data;
  logic [15:0]           wr_count;
`endif

  regfile_sync_read dut (
    .clk      (clk),
    .reset    (reset),
    .halt     (halt),
    .ra_addr  (ra_addr),
    .rb_addr  (rb_addr),
    .we       (we),
    .wtgt     (wtgt),
    .wdata    (wdata),
`ifdef REGFILE_DEBUG_EN
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .wr_count (wr_count),
`endif
    .ra_data  (ra_data),
    .rb_data  (rb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One stimulus cycle: drive on the falling edge, queue what the next rising edge must produce.
  task automatic cyc(input string name, input logic h, input logic w,
                     input logic [2:0] t, input logic [15:0] d,
                     input logic [2:0] a, input logic [2:0] b,
                     input logic [15:0] ea, input logic [15:0] eb);
    exp_t e;
    @(negedge clk);
    halt = h; we = w; wtgt = t; wdata = d; ra_addr = a; rb_addr = b;
    e.name = name; e.exp_a = ea; e.exp_b = eb;
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, ".a"}, ra_data, e.exp_a);
      check({e.name, ".b"}, rb_data, e.exp_b);
    end
  end

  initial begin
    reset = 1'b1; halt = 1'b0; we = 1'b0; wtgt = '0; wdata = '0;
    ra_addr = 3'd3; rb_addr = 3'd5;
`ifdef REGFILE_DEBUG_EN
    dbg_addr = '0;
`endif
    #3;
    check("rst_imm.a", ra_data, 16'h0000);
    check("rst_imm.b", rb_data, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    //   name         halt we  tgt   data      ra    rb    exp_a     exp_b
    cyc("rst_read",   0,  1, 3'd2, 16'hBEEF, 3'd3, 3'd5, 16'h0000, 16'h0000);
    cyc("readback",   0,  0, 3'd0, 16'h0000, 3'd2, 3'd0, 16'hBEEF, 16'h0000);
    cyc("pre_byp",    0,  1, 3'd4, 16'h1111, 3'd2, 3'd2, 16'hBEEF, 16'hBEEF);
    cyc("bypass",     0,  1, 3'd4, 16'h1234, 3'd4, 3'd4, 16'h1234, 16'h1234);
    cyc("post_byp",   0,  0, 3'd0, 16'h0000, 3'd4, 3'd2, 16'h1234, 16'hBEEF);
    cyc("r0_write",   0,  1, 3'd0, 16'hFFFF, 3'd0, 3'd0, 16'h0000, 16'h0000);
    cyc("r0_read",    0,  0, 3'd0, 16'h0000, 3'd0, 3'd4, 16'h0000, 16'h1234);
    cyc("halt_setup", 0,  0, 3'd0, 16'h0000, 3'd6, 3'd2, 16'h0000, 16'hBEEF);
    cyc("halt_hold",  1,  0, 3'd0, 16'h0000, 3'd1, 3'd3, 16'h0000, 16'hBEEF);
    cyc("halt_wr6",   1,  1, 3'd6, 16'h00AA, 3'd1, 3'd3, 16'h00AA, 16'hBEEF);
    cyc("halt_wr2",   1,  1, 3'd2, 16'hCAFE, 3'd1, 3'd3, 16'h00AA, 16'hCAFE);
    cyc("unhalt",     0,  1, 3'd3, 16'h5A5A, 3'd1, 3'd3, 16'h0000, 16'h5A5A);
    cyc("reread",     0,  0, 3'd0, 16'h0000, 3'd6, 3'd3, 16'h00AA, 16'h5A5A);
    cyc("halt_again", 1,  0, 3'd0, 16'h0000, 3'd0, 3'd0, 16'h00AA, 16'h5A5A);

    // Reset asserted mid-cycle while a write to r5 is pending.
    @(negedge clk);
    halt = 1'b0; we = 1'b1; wtgt = 3'd5; wdata = 16'h7777; ra_addr = 3'd5; rb_addr = 3'd5;
    #2 reset = 1'b1;
    #1;
    check("midrst_imm.a", ra_data, 16'h0000);
    check("midrst_imm.b", rb_data, 16'h0000);
    @(posedge clk);
    #1;
    check("midrst_edge.a", ra_data, 16'h0000);
    check("midrst_edge.b", rb_data, 16'h0000);
    @(negedge clk);
    reset = 1'b0; we = 1'b0;

    cyc("clr_r3w1",   0,  1, 3'd3, 16'h0001, 3'd5, 3'd2, 16'h0000, 16'h0000);
    cyc("r3w2",       0,  1, 3'd3, 16'h0002, 3'd6, 3'd3, 16'h0000, 16'h0002);
    cyc("r3w3",       0,  1, 3'd3, 16'h0003, 3'd7, 3'd1, 16'h0000, 16'h0000);
    cyc("r0w",        0,  1, 3'd0, 16'hFFFF, 3'd3, 3'd0, 16'h0003, 16'h0000);

`ifdef REGFILE_DEBUG_EN
    @(negedge clk);
    we = 1'b0;
    dbg_addr = 3'd3;
    #1;
    check("wr_count", wr_count, 16'd3);
    check("dbg_r3", dbg_data, 16'h0003);
    dbg_addr = 3'd0;
    #1;
    check("dbg_r0", dbg_data, 16'h0000);
`endif

    cyc("final",      0,  1, 3'd7, 16'h8001, 3'd7, 3'd3, 16'h8001, 16'h0003);
    @(negedge clk);
    we = 1'b0;

    for (int i = 0; i < 10 && sb.size() != 0; i++)
      @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
